// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit: operation encoding
// and default geometry.
package addsub_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 2;

    // Carry-in that turns A + ~B into a two's-complement subtract.
    function automatic logic op_cin(input op_e op);
        return (op == OP_SUB);
    endfunction

endpackage

// File: rtl/addsub_if.sv
// Handshake and payload bundle between a producer, the add/sub pipeline and
// its consumer.
interface addsub_if
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    op_e              sel_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] s_o;
    logic             c_o;
    logic             v_o;
    logic             z_o;

    modport master (
        output in_valid_i, a_i, b_i, sel_i, out_ready_i,
        input  in_ready_o, out_valid_o, s_o, c_o, v_o, z_o
    );

    modport slave (
        input  in_valid_i, a_i, b_i, sel_i, out_ready_i,
        output in_ready_o, out_valid_o, s_o, c_o, v_o, z_o
    );

endinterface

// File: rtl/addsub_seg.sv
// Combinational adder for one carry-chain segment; also exposes the carry
// into its top bit so the last segment can derive signed overflow.
module addsub_seg #(
    parameter int SEG_W = 16
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    if (SEG_W == 1) begin : g_bit
        logic [1:0] t;
        assign t    = {1'b0, a} + {1'b0, b} + {1'b0, cin};
        assign sum  = t[0];
        assign cout = t[1];
        assign cmsb = cin;
    end else begin : g_vec
        logic [SEG_W-1:0] low;
        logic [1:0]       top;

        // Add everything below the MSB first so its carry-out is visible.
        assign low  = {1'b0, a[SEG_W-2:0]} + {1'b0, b[SEG_W-2:0]}
                    + {{(SEG_W-1){1'b0}}, cin};
        assign cmsb = low[SEG_W-1];
        assign top  = {1'b0, a[SEG_W-1]} + {1'b0, b[SEG_W-1]} + {1'b0, cmsb};
        assign sum  = {top[0], low[SEG_W-2:0]};
        assign cout = top[1];
    end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract: the carry chain is cut into STAGES segments, one per
// register stage, with a single global advance enable for backpressure.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic     clk_i,
    input  logic     rst_i,
    addsub_if.slave  bus
);

    localparam int SEG_W = WIDTH / STAGES;

    if ((WIDTH < 2) || (STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_cfg_err
        $error("addsub_pipe: WIDTH must be >= 2 and divisible by STAGES");
    end

    logic             en;
    logic             cin0;
    logic [WIDTH-1:0] b_eff;

    // Every stage advances together; a stalled, full output freezes the pipe.
    assign en             = bus.out_ready_i | ~bus.out_valid_o;
    assign bus.in_ready_o = en;
    assign cin0           = op_cin(bus.sel_i);
    assign b_eff          = cin0 ? ~bus.b_i : bus.b_i;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int SRC_W  = WIDTH - k * SEG_W;
        localparam int DONE_W = (k + 1) * SEG_W;

        logic [SRC_W-1:0]  a_src;
        logic [SRC_W-1:0]  b_src;
        logic              cin_src;
        logic              vld_src;
        logic [SEG_W-1:0]  seg_sum;
        logic              seg_cout;
        logic              seg_cmsb;
        logic [DONE_W-1:0] sum_d;

        logic              vld_q;
        logic [DONE_W-1:0] sum_q;
        logic              cy_q;

        if (k == 0) begin : g_src
            assign a_src   = bus.a_i;
            assign b_src   = b_eff;
            assign cin_src = cin0;
            assign vld_src = bus.in_valid_i;
            assign sum_d   = seg_sum;
        end else begin : g_src
            assign a_src   = g_stg[k-1].g_fwd.a_q;
            assign b_src   = g_stg[k-1].g_fwd.b_q;
            assign cin_src = g_stg[k-1].cy_q;
            assign vld_src = g_stg[k-1].vld_q;
            // Completed low segments ride along so the result lands aligned.
            assign sum_d   = {seg_sum, g_stg[k-1].sum_q};
        end

        addsub_seg #(
            .SEG_W (SEG_W)
        ) u_seg (
            .a    (a_src[SEG_W-1:0]),
            .b    (b_src[SEG_W-1:0]),
            .cin  (cin_src),
            .sum  (seg_sum),
            .cout (seg_cout),
            .cmsb (seg_cmsb)
        );

        // ---- stage k register boundary ----
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                vld_q <= 1'b0;
            end else if (en) begin
                vld_q <= vld_src;
            end
        end

        if (k != STAGES - 1) begin : g_fwd
            logic [SRC_W-SEG_W-1:0] a_q;
            logic [SRC_W-SEG_W-1:0] b_q;
            logic                   unused_cmsb;

            assign unused_cmsb = seg_cmsb;

            always_ff @(posedge clk_i) begin
                if (en) begin
                    a_q   <= a_src[SRC_W-1:SEG_W];
                    b_q   <= b_src[SRC_W-1:SEG_W];
                    sum_q <= sum_d;
                    cy_q  <= seg_cout;
                end
            end
        end else begin : g_out
            logic ovf_q;
            logic zero_q;

            // Payload only loads with valid data, so bubbles never disturb it.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    sum_q  <= '0;
                    cy_q   <= 1'b0;
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (en && vld_src) begin
                    sum_q  <= sum_d;
                    cy_q   <= seg_cout;
                    ovf_q  <= seg_cmsb ^ seg_cout;
                    zero_q <= ~|sum_d;
                end
            end
        end
    end

    assign bus.out_valid_o = g_stg[STAGES-1].vld_q;
    assign bus.s_o         = g_stg[STAGES-1].sum_q;
    assign bus.c_o         = g_stg[STAGES-1].cy_q;
    assign bus.v_o         = g_stg[STAGES-1].g_out.ovf_q;
    assign bus.z_o         = g_stg[STAGES-1].g_out.zero_q;

endmodule

// File: doc/addsub_pipe.md
ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits, minimum 2.
REQ-002 SHALL have parameter STAGES, default 2: number of pipeline stages (carry-chain segments); WIDTH SHALL be divisible by STAGES (elaboration error otherwise).
REQ-003 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid_i  input  1  operands and operation valid.
REQ-006 SHALL have port in_ready_o  output  1  block accepts an operation this cycle.
REQ-007 SHALL have port a_i  input  WIDTH  operand A.
REQ-008 SHALL have port b_i  input  WIDTH  operand B.
REQ-009 SHALL have port sel_i  input  1  operation: 0 = A+B, 1 = A-B.
REQ-010 SHALL have port out_valid_o  output  1  result valid.
REQ-011 SHALL have port out_ready_i  input  1  consumer accepts the result.
REQ-012 SHALL have port s_o  output  WIDTH  result, modulo 2^WIDTH.
REQ-013 SHALL have port c_o  output  1  carry out of the MSB; for subtract, 1 = no borrow (A >= B unsigned).
REQ-014 SHALL have port v_o  output  1  two's-complement signed overflow.
REQ-015 SHALL have port z_o  output  1  s_o equals zero.

Function
REQ-016 SHALL compute subtract as A + ~B + 1, i.e. B inverted with carry-in 1; add uses carry-in 0.
REQ-017 SHALL split the carry chain into STAGES segments of WIDTH/STAGES bits; stage k adds segment k using the carry registered from stage k-1.
REQ-018 SHALL carry unprocessed operand segments forward in stage registers, and SHALL deskew completed result segments so s_o is aligned in the final stage.
REQ-019 SHALL have latency exactly STAGES cycles from an accepted input (in_valid_i and in_ready_o high at an edge) to out_valid_o high, when out_ready_i stays high.
REQ-020 SHALL sustain one operation per cycle when out_ready_i is held high.
REQ-021 SHALL use one global advance enable: en = out_ready_i OR NOT out_valid_o; in_ready_o SHALL equal en, combinationally.
REQ-022 SHALL hold all stage registers, including payload and valid bits, when en is low; s_o, c_o, v_o, z_o and out_valid_o SHALL remain stable while out_valid_o is high and out_ready_i is low.
REQ-023 SHALL shift a bubble (valid 0) into stage 0 when en is high and in_valid_i is low.
REQ-024 SHALL deliver results strictly in acceptance order, with no loss or duplication under any out_ready_i pattern.
REQ-025 SHALL compute v_o as carry into MSB XOR carry out of MSB, and z_o as NOR of all s_o bits.
REQ-026 SHALL treat flag outputs as don't-care while out_valid_o is low; they SHALL be driven from registers, never X.

Reset
REQ-027 SHALL clear every stage valid bit to 0 on the first clk_i edge with rst_i high; out_valid_o SHALL be 0 from then until new data completes.
REQ-028 SHALL reset s_o, c_o, v_o and z_o to 0.
REQ-029 SHALL discard any operations in flight when reset is asserted mid-operation; none of them SHALL emerge after reset.
REQ-030 SHALL NOT accept an input on an edge where rst_i is high.
REQ-031 SHALL hold in_ready_o at 1 after reset (the pipeline is empty).

Structure
REQ-032 SHALL take from shared package addsub_pkg: the op encoding typedef (OP_ADD = 0, OP_SUB = 1) and the default WIDTH/STAGES constants.
REQ-033 SHALL instantiate STAGES copies of one sub-module, addsub_seg: a combinational segment adder, parameter SEG_W, inputs a, b, cin; outputs sum, cout, and carry into its MSB.

Verification
REQ-034 SHALL test, at WIDTH=32 and STAGES=2, add 0xFFFFFFFF + 0x00000001 -> at cycle +2: s=0x00000000, c=1, v=0, z=1.
REQ-035 SHALL test add 0x7FFFFFFF + 0x00000001 -> s=0x80000000, c=0, v=1, z=0.
REQ-036 SHALL test sub 0x00000005 - 0x00000007 -> s=0xFFFFFFFE, c=0, v=0; and sub 0x80000000 - 0x00000001 -> s=0x7FFFFFFF, c=1, v=1.
REQ-037 SHALL test backpressure: issue 4 back-to-back ops with out_ready_i low for 3 cycles -> in_ready_o drops once the final stage holds valid data, outputs stay stable, and all 4 results emerge in order, once each.
REQ-038 SHALL test reset mid-operation: assert rst_i with 2 ops in flight -> out_valid_o = 0 the next cycle, and neither op ever appears.
REQ-039 SHALL run 100 random ops per mode, at STAGES of 1, 2 and 4 and random out_ready_i, each checked against a behavioural A±B model for s, c, v and z.
